// File: rtl/spi_cmd_master_pkg.sv
// spi_cmd_master shared types: FSM state encoding, default frame width
// and counter-width helpers used by the master and its sclk divider.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int DEF_VALUE_WIDTH = 32;
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_CS_TIME     = 2;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int DEF_DIV_W = cnt_w(DEF_CLK_DIV);
    localparam int DEF_PH_W  = cnt_w(DEF_CS_TIME);

endpackage

// File: rtl/spi_cmd_master_if.sv
// Command/handshake and SPI pin bundle of spi_cmd_master.
// master modport is the DUT side; slave modport is the user/pin side.
interface spi_cmd_master_if
    import spi_cmd_pkg::*;
#(
    parameter int VALUE_WIDTH = DEF_VALUE_WIDTH
);
    logic                   startTrigger;
    logic [VALUE_WIDTH-1:0] txValue;
    logic                   busy;
    logic [VALUE_WIDTH-1:0] rxValue;
    logic                   rxDoneTrigger;
    logic                   spi_cs;
    logic                   spi_sclk;
    logic                   spi_mosi;
    logic                   spi_miso;

    modport master (
        input  startTrigger, txValue, spi_miso,
        output busy, rxValue, rxDoneTrigger,
        output spi_cs, spi_sclk, spi_mosi
    );

    modport slave (
        output startTrigger, txValue, spi_miso,
        input  busy, rxValue, rxDoneTrigger,
        input  spi_cs, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_cmd_master_sclk_gen.sv
// sclk divider: toggles sclk every CLK_DIV enabled cycles and flags the
// rising/falling toggle edges; held cleared whenever not enabled.
module spi_sclk_gen
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rest,
    input  logic i_en,
    output logic o_sclk,
    output logic o_riseEn,
    output logic o_fallEn
);
    localparam int DIV_W = cnt_w(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_tc;

    assign w_tc     = i_en && (r_div == DIV_W'(CLK_DIV - 1));
    assign o_riseEn = w_tc && !r_sclk;
    assign o_fallEn = w_tc && r_sclk;
    assign o_sclk   = r_sclk;

    // Half-period divider; sclk returns low as soon as enable drops.
    always_ff @(posedge clk) begin
        if (rest || !i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: full-duplex MSB-first frame per start.
// Optional SPI_CMD_MASTER_BURST_EN chains frames under one cs envelope.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int CS_SETUP    = DEF_CS_TIME,
    parameter int CS_HOLD     = DEF_CS_TIME,
    parameter int CS_GAP      = DEF_CS_TIME
) (
    input  logic clk,
    input  logic rest,
    spi_cmd_master_if.master io_bus
);
    localparam int PH_W  = cnt_w(max3(CS_SETUP, CS_HOLD, CS_GAP));
    localparam int BIT_W = cnt_w(VALUE_WIDTH);

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [PH_W-1:0]        r_phCnt;
    logic [PH_W-1:0]        w_phLim;
    logic [BIT_W-1:0]       r_bitCnt;
    logic [VALUE_WIDTH-1:0] r_tx;
    logic [VALUE_WIDTH-1:0] r_rx;
    logic [VALUE_WIDTH-1:0] r_rxValue;
    logic                   r_cs;
    logic                   r_mosi;
    logic                   r_busy;
    logic                   r_rxDone;
    logic                   w_sclk;
    logic                   w_riseEn;
    logic                   w_fallEn;
    logic                   w_shiftEn;
    logic                   w_phLast;
    logic                   w_bitLast;
    logic                   w_load;
    logic                   w_holdDone;

    assign w_shiftEn = (r_state == ST_SHIFT);
    assign w_phLast  = (r_phCnt == w_phLim);
    assign w_bitLast = (r_bitCnt == BIT_W'(VALUE_WIDTH - 1));

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .rest     (rest),
        .i_en     (w_shiftEn),
        .o_sclk   (w_sclk),
        .o_riseEn (w_riseEn),
        .o_fallEn (w_fallEn)
    );

    assign io_bus.spi_cs        = r_cs;
    assign io_bus.spi_sclk      = w_sclk;
    assign io_bus.spi_mosi      = r_mosi;
    assign io_bus.busy          = r_busy;
    assign io_bus.rxValue       = r_rxValue;
    assign io_bus.rxDoneTrigger = r_rxDone;

    // State register.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state, phase length and frame load / completion strobes.
    always_comb begin
        w_stateNext = r_state;
        w_phLim     = '0;
        w_load      = 1'b0;
        w_holdDone  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (io_bus.startTrigger) begin
                    w_stateNext = ST_SETUP;
                    w_load      = 1'b1;
                end
            end
            ST_SETUP: begin
                w_phLim = PH_W'(CS_SETUP - 1);
                if (w_phLast) begin
                    w_stateNext = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_fallEn && w_bitLast) begin
                    w_stateNext = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_phLim = PH_W'(CS_HOLD - 1);
                if (w_phLast) begin
                    w_holdDone  = 1'b1;
                    w_stateNext = ST_GAP;
`ifdef SPI_CMD_MASTER_BURST_EN
                    if (io_bus.startTrigger) begin
                        w_stateNext = ST_SHIFT;
                        w_load      = 1'b1;
                    end
`endif
                end
            end
            ST_GAP: begin
                w_phLim = PH_W'(CS_GAP - 1);
                if (w_phLast) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Phase and bit counters; phase restarts on every state change.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_phCnt  <= '0;
            r_bitCnt <= '0;
        end else begin
            if (w_stateNext != r_state) begin
                r_phCnt <= '0;
            end else if (r_state == ST_SETUP || r_state == ST_HOLD ||
                         r_state == ST_GAP) begin
                r_phCnt <= r_phCnt + PH_W'(1);
            end
            if (w_load) begin
                r_bitCnt <= '0;
            end else if (w_fallEn) begin
                r_bitCnt <= r_bitCnt + BIT_W'(1);
            end
        end
    end

    // Shift datapath, cs/mosi pins, busy and receive result.
    always_ff @(posedge clk) begin
        if (rest) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_rxValue <= '0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_rxDone  <= 1'b0;
        end else begin
            r_busy   <= (w_stateNext != ST_IDLE);
            r_rxDone <= 1'b0;
            if (w_riseEn) begin
                r_rx <= {r_rx[VALUE_WIDTH-2:0], io_bus.spi_miso};
            end
            if (w_fallEn && !w_bitLast) begin
                r_mosi <= r_tx[VALUE_WIDTH-2];
                r_tx   <= r_tx << 1;
            end
            if (w_holdDone) begin
                r_rxValue <= r_rx;
                r_rxDone  <= 1'b1;
                r_cs      <= 1'b1;
                r_mosi    <= 1'b0;
            end
            // A load in the last hold cycle overrides the cs release.
            if (w_load) begin
                r_tx   <= io_bus.txValue;
                r_mosi <= io_bus.txValue[VALUE_WIDTH-1];
                r_cs   <= 1'b0;
            end
        end
    end

endmodule
